// File: rtl/l2_if_pkg.sv
// l2_if_pkg: shared command codes, request struct and queue FSM states for the L1-to-L2 request path
package l2_if_pkg;
  localparam int L2_ADDR_W = 26;
  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_READ = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_RSVD = 2'b11;
  typedef struct packed {
    logic [1:0] cmd;
    logic [L2_ADDR_W-1:0] add;
  } req_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} q_state_t;
endpackage

// File: rtl/l2q_fifo_mem.sv
// l2q_fifo_mem: DEPTH x W register array; write port (we, wptr, wdata), enabled registered read port (re, rptr -> rdata) with write-through when both hit the same slot
module l2q_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] wptr,
  input  logic [W-1:0]     wdata,
  input  logic             re,
  input  logic [PTR_W-1:0] rptr,
  output logic [W-1:0]     rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wptr] <= wdata;
  // Forwarding covers a push into a slot that becomes the head at the same edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= (we && wptr == rptr) ? wdata : mem[rptr];
endmodule

// File: rtl/l2_request_queue.sv
// l2_request_queue: drop-on-overflow FIFO between L1 next-level commands (cmd_in/add_in) and L2 valid/ready (req_*); reports occupancy, enq_count, drop_count, sticky cmd_err; optional WRITE merge under L2Q_WRITE_MERGE_EN
module l2_request_queue
  import l2_if_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int ADDR_W = L2_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cmd_in,
  input  logic [ADDR_W-1:0] add_in,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [1:0]        req_cmd,
  output logic [ADDR_W-1:0] req_add,
  output logic [PTR_W:0]    occupancy,
  output logic [31:0]       enq_count,
  output logic [31:0]       drop_count,
  output logic              cmd_err
);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(DEPTH);
  q_state_t state, state_nxt;
  logic [PTR_W-1:0] rptr, wptr, rptr_nxt;
  logic [PTR_W:0] occ_nxt;
  logic push, pop, full, merge, enq, drop;
  assign push = cmd_in == CMD_READ || cmd_in == CMD_WRITE;
  assign pop = req_valid && req_ready;
  assign full = occupancy == FULL_OCC;
`ifdef L2Q_WRITE_MERGE_EN
  logic tail_wr;
  logic [ADDR_W-1:0] tail_add;
  // A lone entry that is leaving this edge is not a merge target.
  assign merge = cmd_in == CMD_WRITE && occupancy != '0 && tail_wr && tail_add == add_in && !(pop && occupancy == (PTR_W+1)'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tail_wr <= 1'b0;
      tail_add <= '0;
    end else if (enq) begin
      tail_wr <= cmd_in == CMD_WRITE;
      tail_add <= add_in;
    end
`else
  assign merge = 1'b0;
`endif
  assign enq = push && !merge && (!full || pop);
  assign drop = push && !merge && full && !pop;
  assign occ_nxt = occupancy + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
  assign rptr_nxt = rptr + PTR_W'(pop);
  assign req_valid = state != ST_EMPTY;
  always_comb begin
    state_nxt = state;
    state_nxt = occ_nxt == '0 ? ST_EMPTY : occ_nxt == FULL_OCC ? ST_FULL : ST_PARTIAL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_EMPTY;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      occupancy <= '0;
      enq_count <= '0;
      drop_count <= '0;
      cmd_err <= 1'b0;
    end else begin
      rptr <= rptr_nxt;
      wptr <= wptr + PTR_W'(enq);
      occupancy <= occ_nxt;
      enq_count <= enq_count + 32'(enq || merge);
      drop_count <= drop_count + 32'(drop);
      cmd_err <= cmd_err || cmd_in == CMD_RSVD;
    end
  logic [ADDR_W+1:0] head;
  l2q_fifo_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(ADDR_W + 2)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (enq),
    .wptr  (wptr),
    .wdata ({cmd_in, add_in}),
    .re    (pop || (enq && !req_valid)),
    .rptr  (rptr_nxt),
    .rdata (head)
  );
  assign {req_cmd, req_add} = head;
endmodule

// File: tb/tb_l2_request_queue.sv
// tb_l2_request_queue: directed scenarios plus randomized traffic checked against a queue-based reference model
module tb_l2_request_queue;
  import l2_if_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] cmd_in = CMD_NOP;
  logic [L2_ADDR_W-1:0] add_in = '0;
  logic req_ready = 1'b0;
  logic req_valid;
  logic [1:0] req_cmd;
  logic [L2_ADDR_W-1:0] req_add;
  logic [3:0] occupancy;
  logic [31:0] enq_count, drop_count;
  logic cmd_err;
  int checks = 0;
  int errors = 0;
  req_t mq[$];
  int unsigned m_enq, m_drop;
  bit m_err;

  l2_request_queue #(.DEPTH(DEPTH), .PTR_W(3), .ADDR_W(L2_ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .add_in(add_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_add(req_add),
    .occupancy(occupancy), .enq_count(enq_count), .drop_count(drop_count), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit p, push, mrg, acc;
    req_t r;
    p = mq.size() > 0 && req_ready;
    push = cmd_in == CMD_READ || cmd_in == CMD_WRITE;
    if (cmd_in == CMD_RSVD) m_err = 1;
    mrg = 0;
`ifdef L2Q_WRITE_MERGE_EN
    if (cmd_in == CMD_WRITE && mq.size() > 0)
      mrg = mq[$].cmd == CMD_WRITE && mq[$].add == add_in && !(p && mq.size() == 1);
`endif
    acc = push && !mrg && (mq.size() < DEPTH || p);
    if (push && !mrg && !acc) m_drop++;
    if (acc || mrg) m_enq++;
    if (p) void'(mq.pop_front());
    if (acc) begin
      r.cmd = cmd_in;
      r.add = add_in;
      mq.push_back(r);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] c, input logic [L2_ADDR_W-1:0] a, input logic r);
    cmd_in = c;
    add_in = a;
    req_ready = r;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(CMD_NOP, '0, 1'b0);
    mq.delete();
    m_enq = 0;
    m_drop = 0;
    m_err = 0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (req_valid !== 1'b0 || req_cmd !== 2'b00 || req_add !== '0 || occupancy !== 4'd0 ||
        enq_count !== 32'd0 || drop_count !== 32'd0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b cmd=%b add=%h occ=%0d enq=%0d drop=%0d err=%b, required all zero",
               req_valid, req_cmd, req_add, occupancy, enq_count, drop_count, cmd_err);
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    drive(CMD_READ, 26'h0001234, 1'b1);
    tick();
    drive(CMD_NOP, '0, 1'b1);
    checks++;
    if (req_valid !== 1'b1 || req_cmd !== CMD_READ || req_add !== 26'h0001234 || occupancy !== 4'd1) begin
      errors++;
      $display("FAIL single_read_head: valid=%b cmd=%b add=%h occ=%0d, required 1 01 0001234 1",
               req_valid, req_cmd, req_add, occupancy);
    end
    tick();
    checks++;
    if (req_valid !== 1'b0 || occupancy !== 4'd0 || enq_count !== 32'd1) begin
      errors++;
      $display("FAIL single_read_pop: valid=%b occ=%0d enq=%0d, required 0 0 1", req_valid, occupancy, enq_count);
    end
  endtask

  task automatic test_fill_drop();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(CMD_WRITE, 26'(i), 1'b0);
      tick();
    end
    drive(CMD_NOP, '0, 1'b0);
    checks++;
    if (occupancy !== 4'd8 || enq_count !== 32'd8 || drop_count !== 32'd2 || dut.state !== ST_FULL) begin
      errors++;
      $display("FAIL fill_drop: occ=%0d enq=%0d drop=%0d state=%0d, required 8 8 2 FULL",
               occupancy, enq_count, drop_count, dut.state);
    end
    checks++;
    if (req_valid !== 1'b1 || req_cmd !== CMD_WRITE || req_add !== 26'd0) begin
      errors++;
      $display("FAIL fill_head: valid=%b cmd=%b add=%h, required 1 10 0", req_valid, req_cmd, req_add);
    end
  endtask

  task automatic test_full_push_pop();
    drive(CMD_READ, 26'h77, 1'b1);
    tick();
    drive(CMD_NOP, '0, 1'b0);
    checks++;
    if (occupancy !== 4'd8 || drop_count !== 32'd2 || enq_count !== 32'd9 || dut.state !== ST_FULL) begin
      errors++;
      $display("FAIL full_push_pop: occ=%0d drop=%0d enq=%0d state=%0d, required 8 2 9 FULL",
               occupancy, drop_count, enq_count, dut.state);
    end
    checks++;
    if (req_add !== 26'd1 || req_cmd !== CMD_WRITE) begin
      errors++;
      $display("FAIL full_head_advance: cmd=%b add=%h, required 10 1", req_cmd, req_add);
    end
  endtask

  task automatic test_order_stall();
    logic [27:0] exp [3];
    logic [27:0] got[$];
    logic [27:0] prev;
    bit stalled;
    exp[0] = {CMD_READ, 26'h0A};
    exp[1] = {CMD_WRITE, 26'h0B};
    exp[2] = {CMD_READ, 26'h0C};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(exp[i][27:26], exp[i][25:0], 1'b0);
      tick();
    end
    drive(CMD_NOP, '0, 1'b0);
    stalled = 0;
    prev = '0;
    for (int i = 0; i < 12; i++) begin
      if (stalled) begin
        checks++;
        if ({req_cmd, req_add} !== prev) begin
          errors++;
          $display("FAIL stall_stable: head=%h, required %h", {req_cmd, req_add}, prev);
        end
      end
      req_ready = (i % 4) < 2 ? 1'b0 : 1'b1;
      stalled = req_valid && !req_ready;
      prev = {req_cmd, req_add};
      if (req_valid && req_ready) got.push_back({req_cmd, req_add});
      tick();
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL order_count: popped %0d, required 3", got.size());
    end else
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL order_%0d: got %h, required %h", i, got[i], exp[i]);
        end
      end
  endtask

  task automatic test_cmd_err();
    apply_reset();
    drive(CMD_READ, 26'h3, 1'b0);
    tick();
    drive(CMD_RSVD, 26'h4, 1'b0);
    tick();
    drive(CMD_NOP, '0, 1'b0);
    checks++;
    if (cmd_err !== 1'b1 || occupancy !== 4'd1 || enq_count !== 32'd1 || drop_count !== 32'd0) begin
      errors++;
      $display("FAIL cmd_err_set: err=%b occ=%0d enq=%0d drop=%0d, required 1 1 1 0",
               cmd_err, occupancy, enq_count, drop_count);
    end
    tick();
    tick();
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL cmd_err_sticky: err=%b, required 1", cmd_err);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_err !== 1'b0 || req_valid !== 1'b0 || occupancy !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: err=%b valid=%b occ=%0d, required 0 0 0", cmd_err, req_valid, occupancy);
    end
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_merge();
    logic [3:0] exp_occ;
`ifdef L2Q_WRITE_MERGE_EN
    exp_occ = 4'd2;
`else
    exp_occ = 4'd3;
`endif
    apply_reset();
    drive(CMD_WRITE, 26'h55, 1'b0);
    tick();
    drive(CMD_WRITE, 26'h55, 1'b0);
    tick();
    drive(CMD_READ, 26'h55, 1'b0);
    tick();
    drive(CMD_NOP, '0, 1'b0);
    checks++;
    if (occupancy !== exp_occ || enq_count !== 32'd3) begin
      errors++;
      $display("FAIL merge: occ=%0d enq=%0d, required %0d 3", occupancy, enq_count, exp_occ);
    end
  endtask

  task automatic test_random();
    int thr, r;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      thr = ((i / 300) % 2 == 0) ? 25 : 85;
      r = $urandom_range(0, 99);
      cmd_in = r < 30 ? CMD_NOP : r < 60 ? CMD_READ : r < 99 ? CMD_WRITE : CMD_RSVD;
      add_in = $urandom_range(0, 1) ? 26'h55 : 26'($urandom_range(0, 3));
      req_ready = $urandom_range(0, 99) < thr;
      tick();
      checks++;
      if (req_valid !== (mq.size() > 0) || int'(occupancy) != mq.size()) begin
        errors++;
        $display("FAIL rand_occ @%0d: valid=%b occ=%0d, required %b %0d", i, req_valid, occupancy, mq.size() > 0, mq.size());
      end
      if (mq.size() > 0) begin
        checks++;
        if (req_cmd !== mq[0].cmd || req_add !== mq[0].add) begin
          errors++;
          $display("FAIL rand_head @%0d: cmd=%b add=%h, required %b %h", i, req_cmd, req_add, mq[0].cmd, mq[0].add);
        end
      end
      checks++;
      if (enq_count !== m_enq || drop_count !== m_drop || cmd_err !== m_err) begin
        errors++;
        $display("FAIL rand_cnt @%0d: enq=%0d drop=%0d err=%b, required %0d %0d %b",
                 i, enq_count, drop_count, cmd_err, m_enq, m_drop, m_err);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_read();
    test_fill_drop();
    test_full_push_pop();
    test_order_stall();
    test_cmd_err();
    test_merge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2_request_queue.md
Name: l2_request_queue

Overview:
- Sits directly downstream of the L1 data cache.
- Captures the cache's per-cycle next-level command (READ_OUT / WRITE_OUT plus the 26-bit line address) and buffers it in a FIFO.
- Drains entries to the L2 / next-level model over a valid/ready handshake.
- The L1 never stalls, so overflow is dropped and counted, not back-pressured. Queue statistics go to the statistics module.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, 2..64.
- PTR_W, 3, log2(DEPTH); pointer width.
- ADDR_W, 26, line-address width (address bits [31:6]).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  reset is asynchronous and active-low.
- cmd_in  input  2  L1 command: 00 NOP, 01 READ, 10 WRITE, 11 reserved.
- add_in  input  ADDR_W  line address accompanying cmd_in; ignored on NOP.
- req_valid  output  1  head entry is presented to L2.
- req_ready  input  1  L2 accepts the head entry this cycle.
- req_cmd  output  2  head command (01/10).
- req_add  output  ADDR_W  head line address.
- occupancy  output  PTR_W+1  current entry count, 0..DEPTH.
- enq_count  output  32  commands accepted since reset.
- drop_count  output  32  commands lost to overflow.
- cmd_err  output  1  sticky; set when cmd_in==11 is seen.

Behaviour:
- Reset (async assert, sync release): both pointers 0, occupancy 0, req_valid 0, req_cmd 00, req_add 0, enq_count 0, drop_count 0, cmd_err 0.
- Push: cmd_in is 01 or 10 at a posedge.
- NOP: no effect.
- cmd_in 11: sets cmd_err; never enqueued or counted.
- Accept rule:
  - Push is accepted if occupancy < DEPTH.
  - Push is also accepted if occupancy == DEPTH and a pop happens at the same edge; the freed slot is reused.
  - Otherwise the push is dropped and drop_count increments.
- Pop: req_valid && req_ready at a posedge.
  - Head advances; req_cmd / req_add change only on a pop or on empty-to-non-empty.
- Latency: no bypass.
  - A push into an empty queue makes req_valid 1 from the next cycle.
  - req_cmd / req_add are registered and stable while req_valid && !req_ready.
- occupancy update: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Pointers wrap modulo DEPTH. Full/empty are derived from occupancy, not from pointer equality.
- Counters:
  - enq_count increments on every accepted push.
  - Both counters wrap at 2^32 silently.
- Order is strict FIFO; READ and WRITE are never reordered.
- Reset mid-drain: queue contents discarded and req_valid drops asynchronously. L2 must treat any unhandshaken request as never issued.
- req_ready while req_valid==0 has no effect.
- States (two-bit FSM mirroring occupancy): EMPTY, PARTIAL, FULL.
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL on push without pop at occupancy DEPTH-1.
  - FULL -> PARTIAL on pop without push.
  - PARTIAL -> EMPTY on pop without push at occupancy 1.

Optional Feature:
- Macro: L2Q_WRITE_MERGE_EN.
- Defined: an incoming WRITE whose add_in equals the tail entry's address, with the tail also a WRITE, is merged.
  - Not enqueued, occupancy unchanged, enq_count still increments.
  - Never merges into the head entry while it is being popped in the same cycle.
  - When full, a merge is not a drop.
- Undefined: every WRITE is enqueued separately.

Decomposition:
- Package l2_if_pkg:
  - command codes CMD_NOP / CMD_READ / CMD_WRITE / CMD_RSVD.
  - ADDR_W default.
  - request struct {cmd, add}.
  - FSM state enum.
- Sub-module l2q_fifo_mem: DEPTH x (2+ADDR_W) register array with write port (wptr, wdata, we) and registered read port (rptr). The top holds pointers, FSM, counters and merge logic.

Test Plan:
- Reset, then push READ 0x0001234; req_ready=1 -> req_valid rises the next cycle with req_cmd=01, req_add=0x0001234; occupancy returns to 0 after the pop.
- req_ready=0; push 10 WRITEs -> occupancy=8, enq_count=8, drop_count=2, FSM FULL.
- Full queue, same-cycle push and pop -> push accepted, occupancy stays 8, drop_count unchanged.
- Push READ A, WRITE B, READ C with req_ready toggling 1/0 -> output order A,B,C; values held stable while stalled.
- cmd_in=11 one cycle -> cmd_err=1 and stays 1; occupancy and enq_count unchanged; rst_n low clears it asynchronously.
- With L2Q_WRITE_MERGE_EN: WRITE 0x55, WRITE 0x55, READ 0x55 -> occupancy=2, enq_count=3. Without the macro: occupancy=3.
